// File: rtl/div_pkg.sv
// Shared types and constants for the divider bus sequencer.
// Imported by div_seq_timer and div_bus_sequencer.
package div_pkg;

    localparam int DIV_W = 6;

    localparam logic [DIV_W-1:0] ERR_QUOTIENT = {DIV_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        LD_HI,
        LD_LO,
        LD_DIV,
        WAIT,
        RD_QUO,
        RESP
    } state_t;

endpackage

// File: rtl/div_seq_timer.sv
// Clearable saturating up-counter that watches the divider wait.
// expired is high while the count equals TIMEOUT.
module div_seq_timer
    import div_pkg::*;
#(
    parameter int TIMEOUT = 31
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired = (cnt_q == TW'(TIMEOUT));

    // next count: clear wins, then count up until saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_bus_sequencer.sv
// Valid/ready front-end serialising operands onto the divider bus.
// Define DIV_CHECK_EN to reject zero divisors and quotient overflow.
module div_bus_sequencer
    import div_pkg::*;
#(
    parameter int W       = DIV_W,
    parameter int TIMEOUT = 31
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_dividend,
    input  logic [W-1:0]   in_divisor,
    output logic [W-1:0]   bus_out,
    output logic           div_start,
    input  logic           div_done,
    input  logic [W-1:0]   bus_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_quotient,
    output logic [W-1:0]   out_remainder,
    output logic           out_err
);

    state_t         state_q, state_d;
    logic [2*W-1:0] dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           err_q, err_d;
    logic [W-1:0]   bus_q, bus_d;
    logic           start_q, start_d;
    logic           rdy_q, rdy_d;
    logic           vld_q, vld_d;
    logic           expired;

    div_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q != WAIT),
        .en      (state_q == WAIT),
        .expired (expired)
    );

    // next state, operand latches and result registers
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    dvd_d   = in_dividend;
                    dvs_d   = in_divisor;
                    state_d = LD_HI;
`ifdef DIV_CHECK_EN
                    if ((in_divisor == '0) ||
                        (in_dividend[2*W-1:W] >= in_divisor)) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        quo_d   = ERR_QUOTIENT;
                        rem_d   = in_dividend[2*W-1:W];
                    end
`endif
                end
            end
            LD_HI:  state_d = LD_LO;
            LD_LO:  state_d = LD_DIV;
            LD_DIV: state_d = WAIT;
            WAIT: begin
                if (div_done) begin
                    rem_d   = bus_in;
                    state_d = RD_QUO;
                end else if (expired) begin
                    err_d   = 1'b1;
                    quo_d   = ERR_QUOTIENT;
                    rem_d   = '0;
                    state_d = RESP;
                end
            end
            RD_QUO: begin
                quo_d   = bus_in;
                state_d = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // registered outputs decoded from the upcoming state
    always_comb begin
        rdy_d   = (state_d == IDLE);
        vld_d   = (state_d == RESP);
        start_d = (state_d == LD_HI);
        bus_d   = '0;
        unique case (state_d)
            LD_HI:   bus_d = dvd_d[2*W-1:W];
            LD_LO:   bus_d = dvd_d[W-1:0];
            LD_DIV:  bus_d = dvs_d;
            default: bus_d = '0;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            bus_q   <= '0;
            start_q <= 1'b0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            bus_q   <= bus_d;
            start_q <= start_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready      = rdy_q;
    assign out_valid     = vld_q;
    assign div_start     = start_q;
    assign bus_out       = bus_q;
    assign out_quotient  = quo_q;
    assign out_remainder = rem_q;
    assign out_err       = err_q;

endmodule

// File: tb/tb_div_bus_sequencer.sv
// Directed bench for div_bus_sequencer.
// The bench plays the divider; build with DIV_CHECK_EN to cover checks.
module tb_div_bus_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_dividend;
    logic [5:0]  in_divisor;
    logic [5:0]  bus_out;
    logic        div_start;
    logic        div_done;
    logic [5:0]  bus_in;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_quotient;
    logic [5:0]  out_remainder;
    logic        out_err;

    int n_chk  = 0;
    int n_fail = 0;

    div_bus_sequencer #(
        .W       (6),
        .TIMEOUT (31)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .bus_out       (bus_out),
        .div_start     (div_start),
        .div_done      (div_done),
        .bus_in        (bus_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_err       (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one request through the divider model; q/r are what it returns
    task automatic run_req(input logic [11:0] dvd,
                           input logic [5:0]  dvs,
                           input logic [5:0]  hi,
                           input logic [5:0]  lo,
                           input logic [5:0]  q,
                           input logic [5:0]  r,
                           input int          dly,
                           input int          hold,
                           input bit          keep);
        in_valid    = 1'b1;
        in_dividend = dvd;
        in_divisor  = dvs;
        tick();
        chk("start", div_start, 1);
        chk("beat_hi", bus_out, hi);
        chk("rdy_busy", in_ready, 0);
        if (!keep) in_valid = 1'b0;
        tick();
        chk("start_pulse", div_start, 0);
        chk("beat_lo", bus_out, lo);
        chk("rdy_ld", in_ready, 0);
        tick();
        chk("beat_div", bus_out, dvs);
        tick();
        chk("bus_wait", bus_out, 0);
        repeat (dly) tick();
        div_done = 1'b1;
        bus_in   = r;
        tick();
        chk("vld_rdquo", out_valid, 0);
        div_done = 1'b0;
        bus_in   = q;
        tick();
        bus_in = 6'h00;
        chk("vld", out_valid, 1);
        chk("quo", out_quotient, q);
        chk("rem", out_remainder, r);
        chk("err", out_err, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_vld", out_valid, 1);
            chk("bp_quo", out_quotient, q);
            chk("bp_rem", out_remainder, r);
            chk("bp_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("vld_clr", out_valid, 0);
        chk("rdy_back", in_ready, 1);
        chk("quo_clr", out_quotient, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        div_done    = 1'b0;
        bus_in      = '0;
        out_ready   = 1'b0;
        #2;
        chk("rst_rdy", in_ready, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_bus", bus_out, 0);
        chk("rst_start", div_start, 0);
        chk("rst_err", out_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", in_ready, 1);

        // basic divide: 100 / 7 = 14 rem 2
        run_req(12'd100, 6'd7, 6'h01, 6'h24,
                6'd14, 6'd2, 0, 0, 1'b0);

        // backpressure: 200 / 9 = 22 rem 2
        run_req(12'd200, 6'd9, 6'h03, 6'h08,
                6'd22, 6'd2, 2, 5, 1'b0);

        // timeout: divider never answers
        in_valid    = 1'b1;
        in_dividend = 12'd100;
        in_divisor  = 6'd7;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("to_bus_wait", bus_out, 0);
        repeat (31) tick();
        chk("to_vld_early", out_valid, 0);
        tick();
        chk("to_vld", out_valid, 1);
        chk("to_err", out_err, 1);
        chk("to_quo", out_quotient, 6'h3F);
        chk("to_rem", out_remainder, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("to_err_clr", out_err, 0);
        chk("to_rdy", in_ready, 1);

        // divisor zero
`ifdef DIV_CHECK_EN
        in_valid    = 1'b1;
        in_dividend = 12'd50;
        in_divisor  = 6'd0;
        tick();
        in_valid = 1'b0;
        chk("chk_nostart", div_start, 0);
        if (!out_valid) tick();
        chk("chk_vld", out_valid, 1);
        chk("chk_err", out_err, 1);
        chk("chk_quo", out_quotient, 6'h3F);
        chk("chk_rem", out_remainder, 0);
        chk("chk_nostart2", div_start, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("chk_rdy", in_ready, 1);
`else
        run_req(12'd50, 6'd0, 6'h00, 6'h32,
                6'h3F, 6'h32, 1, 0, 1'b0);
`endif

        // reset while waiting for the divider
        in_valid    = 1'b1;
        in_dividend = 12'd100;
        in_divisor  = 6'd7;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", in_ready, 0);
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_bus", bus_out, 0);
        chk("mid_rst_start", div_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_rdy1", in_ready, 1);
        div_done = 1'b1;
        bus_in   = 6'h15;
        tick();
        div_done = 1'b0;
        bus_in   = 6'h00;
        repeat (3) begin
            tick();
            chk("stray_vld", out_valid, 0);
            chk("stray_rdy", in_ready, 1);
        end

        // back-to-back with in_valid held high
        run_req(12'd500, 6'd13, 6'h07, 6'h34,
                6'd38, 6'd6, 1, 0, 1'b1);
        run_req(12'd63, 6'd1, 6'h00, 6'h3F,
                6'd63, 6'd0, 0, 0, 1'b1);
        run_req(12'd1000, 6'd20, 6'h0F, 6'h28,
                6'd50, 6'd0, 3, 0, 1'b1);
        run_req(12'd4000, 6'd63, 6'h3E, 6'h20,
                6'd63, 6'd31, 2, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
